// File: rtl/fir_sample_demux.sv
// Routes one valid/ready sample stream to one of NUM_OUT registered output lanes,
// by explicit select or round-robin. Optional drop counter: FIR_DEMUX_DROP_CNT_EN.
module fir_sample_demux #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned NUM_OUT = 3,
  parameter int unsigned SEL_W   = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic                     rr_mode,
  output logic [NUM_OUT*WIDTH-1:0] out_data,
  output logic [NUM_OUT-1:0]       out_valid,
  input  logic [NUM_OUT-1:0]       out_ready,
  output logic [SEL_W-1:0]         rr_ptr,
  output logic                     err_sel,
  output logic [7:0]               drop_cnt
);

  typedef enum logic {StEmpty, StFull} lane_state_e;

  lane_state_e      r_state     [NUM_OUT];
  lane_state_e      w_state_nxt [NUM_OUT];
  logic [WIDTH-1:0] r_data      [NUM_OUT];
  logic [SEL_W-1:0] w_tgt;
  logic [SEL_W-1:0] r_rr_ptr;
  logic [SEL_W-1:0] w_rr_ptr_nxt;
  logic             w_tgt_ok;
  logic             w_in_ready;
  logic             w_accept;
  logic [NUM_OUT-1:0] w_load;
  logic [NUM_OUT-1:0] w_full;
  logic             r_err_sel;

  always_comb begin
    w_tgt    = rr_mode ? r_rr_ptr : in_sel;
    w_tgt_ok = ({1'b0, w_tgt} < (SEL_W + 1)'(NUM_OUT));
  end

  // An out-of-range target matches no lane, so it is always ready and loads nothing.
  always_comb begin
    w_in_ready = 1'b1;
    w_load     = '0;
    w_full     = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      w_full[k] = (r_state[k] == StFull);
    end
    for (int k = 0; k < NUM_OUT; k++) begin
      if (w_tgt == SEL_W'(k)) begin
        w_in_ready = !w_full[k] || out_ready[k];
      end
    end
    w_accept = in_valid && w_in_ready;
    for (int k = 0; k < NUM_OUT; k++) begin
      w_load[k] = w_accept && (w_tgt == SEL_W'(k));
    end
  end

  // Lane FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_OUT; k++) r_state[k] <= StEmpty;
    end else begin
      for (int k = 0; k < NUM_OUT; k++) r_state[k] <= w_state_nxt[k];
    end
  end

  // Lane FSM: next state
  always_comb begin
    for (int k = 0; k < NUM_OUT; k++) begin
      w_state_nxt[k] = r_state[k];
      unique case (r_state[k])
        StEmpty: w_state_nxt[k] = w_load[k] ? StFull : StEmpty;
        StFull:  w_state_nxt[k] = (out_ready[k] && !w_load[k]) ? StEmpty : StFull;
        default: w_state_nxt[k] = StEmpty;
      endcase
    end
  end

  // Lane FSM: outputs
  always_comb begin
    out_data  = '0;
    out_valid = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      out_valid[k]               = w_full[k];
      out_data[k*WIDTH +: WIDTH] = r_data[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_OUT; k++) r_data[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_OUT; k++) begin
        if (w_load[k]) r_data[k] <= in_data;
      end
    end
  end

  always_comb begin
    w_rr_ptr_nxt = r_rr_ptr;
    if (w_accept && rr_mode) begin
      w_rr_ptr_nxt = (r_rr_ptr == SEL_W'(NUM_OUT - 1)) ? '0 : r_rr_ptr + SEL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr  <= '0;
      r_err_sel <= 1'b0;
    end else begin
      r_rr_ptr  <= w_rr_ptr_nxt;
      r_err_sel <= w_accept && !w_tgt_ok;
    end
  end

`ifdef FIR_DEMUX_DROP_CNT_EN
  logic [7:0] r_drop_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= 8'h00;
    end else if (w_accept && !w_tgt_ok && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'h01;
    end
  end

  assign drop_cnt = r_drop_cnt;
`else
  assign drop_cnt = 8'h00;
`endif

  assign in_ready = w_in_ready;
  assign rr_ptr   = r_rr_ptr;
  assign err_sel  = r_err_sel;

endmodule

// File: tb/tb_fir_sample_demux.sv
// Scoreboard bench for fir_sample_demux: per-lane expected-data queues plus a small
// occupancy/pointer model, checked once per clock.
module tb_fir_sample_demux;

  localparam int W = 8;
  localparam int N = 3;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [S-1:0] in_sel;
  logic         rr_mode;
  logic [N*W-1:0] out_data;
  logic [N-1:0] out_valid;
  logic [N-1:0] out_ready;
  logic [S-1:0] rr_ptr;
  logic         err_sel;
  logic [7:0]   drop_cnt;

  fir_sample_demux #(.WIDTH(W), .NUM_OUT(N), .SEL_W(S)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .rr_mode   (rr_mode),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rr_ptr    (rr_ptr),
    .err_sel   (err_sel),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  logic [N-1:0] m_valid = '0;
  logic [S-1:0] m_ptr   = '0;
  logic         m_err   = 1'b0;
  logic [7:0]   m_drop  = 8'h00;
  logic [W-1:0] q [N][$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 32'(m_valid));
    check({tag, "_rr_ptr"}, 32'(rr_ptr), 32'(m_ptr));
    check({tag, "_err_sel"}, 32'(err_sel), 32'(m_err));
    check({tag, "_drop_cnt"}, 32'(drop_cnt), 32'(m_drop));
  endtask

  // One clock: drive at negedge, check ready/handshake data before the edge,
  // advance the model at the edge, check registered state at the next negedge.
  task automatic step(input string tag, input logic v, input logic [S-1:0] sel,
                      input logic rr, input logic [W-1:0] d, input logic [N-1:0] ord);
    logic [S-1:0] tgt;
    logic         ok;
    logic         rdy;
    logic         acc;
    logic [W-1:0] e;
    in_valid  = v;
    in_sel    = sel;
    rr_mode   = rr;
    in_data   = d;
    out_ready = ord;
    tgt = rr ? m_ptr : sel;
    ok  = (int'(tgt) < N);
    rdy = 1'b1;
    if (ok) rdy = !m_valid[tgt] || ord[tgt];
    #1;
    check({tag, "_in_ready"}, 32'(in_ready), 32'(rdy));
    for (int k = 0; k < N; k++) begin
      if (m_valid[k] && ord[k]) begin
        e = q[k].pop_front();
        check($sformatf("%s_lane%0d_data", tag, k), 32'(out_data[k*W +: W]), 32'(e));
        m_valid[k] = 1'b0;
      end
    end
    acc = v && rdy;
    @(posedge clk);
    m_err = acc && !ok;
    if (acc && ok) begin
      m_valid[tgt] = 1'b1;
      q[tgt].push_back(d);
    end
`ifdef FIR_DEMUX_DROP_CNT_EN
    if (acc && !ok && m_drop != 8'hFF) m_drop = m_drop + 8'h01;
`endif
    if (acc && rr) m_ptr = (int'(m_ptr) == N - 1) ? '0 : m_ptr + 2'd1;
    @(negedge clk);
    check_state(tag);
  endtask

  initial begin
    // Reset with every input active
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_sel    = 2'd3;
    rr_mode   = 1'b1;
    in_data   = 8'hFF;
    out_ready = 3'b111;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_state("reset");
    rst_n = 1'b1;

    // Addressed load, then back-pressure on a full lane
    step("t2_load", 1'b1, 2'd1, 1'b0, 8'h5A, 3'b000);
    check("t2_lane1_val", 32'(out_data[15:8]), 32'h5A);
    step("t2_blk0", 1'b1, 2'd1, 1'b0, 8'hA5, 3'b000);
    step("t2_blk1", 1'b1, 2'd1, 1'b0, 8'hA5, 3'b000);
    step("t2_rel", 1'b1, 2'd1, 1'b0, 8'hA5, 3'b010);
    step("t2_drain", 1'b0, 2'd1, 1'b0, 8'h00, 3'b010);

    // Pass-through on a full lane being drained
    step("t3_fill", 1'b1, 2'd0, 1'b0, 8'h11, 3'b000);
    step("t3_pass", 1'b1, 2'd0, 1'b0, 8'h22, 3'b001);
    check("t3_lane0_val", 32'(out_data[7:0]), 32'h22);

    // Round-robin back-to-back, all consumers ready
    for (int i = 1; i <= 4; i++) begin
      step($sformatf("t4_rr%0d", i), 1'b1, 2'd3, 1'b1, 8'(i), 3'b111);
    end
    step("t4_drain", 1'b0, 2'd0, 1'b1, 8'h00, 3'b111);

    // Invalid select: discarded, err pulses, lanes untouched
    step("t5_bad0", 1'b1, 2'd3, 1'b0, 8'h77, 3'b000);
    step("t5_bad1", 1'b1, 2'd3, 1'b0, 8'h78, 3'b000);
    step("t5_idle", 1'b0, 2'd3, 1'b0, 8'h00, 3'b000);

    // Build lanes 0 and 2 full with rr_ptr at 2, then reset asynchronously
    step("t6_rr", 1'b1, 2'd0, 1'b1, 8'h33, 3'b111);
    step("t6_drain", 1'b0, 2'd0, 1'b0, 8'h00, 3'b111);
    step("t6_l0", 1'b1, 2'd0, 1'b0, 8'h44, 3'b000);
    step("t6_l2", 1'b1, 2'd2, 1'b0, 8'h55, 3'b000);
    check("t6_pre_valid", 32'(out_valid), 32'h5);
    check("t6_pre_ptr", 32'(rr_ptr), 32'h2);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_valid", 32'(out_valid), 32'h0);
    check("t6_async_ptr", 32'(rr_ptr), 32'h0);
    m_valid = '0;
    m_ptr   = '0;
    m_err   = 1'b0;
    m_drop  = 8'h00;
    for (int k = 0; k < N; k++) q[k].delete();
    @(negedge clk);
    check_state("t6_reset");
    rst_n = 1'b1;

    step("t7_load", 1'b1, 2'd2, 1'b0, 8'h66, 3'b000);
    step("t7_drain", 1'b0, 2'd2, 1'b0, 8'h00, 3'b100);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
